// File: rtl/btb_assoc_pkg.sv
// Shared definitions for the set-associative BTB: branch-type encodings, default
// geometry, clear-FSM states and the index-hash macro that gshare also uses.
package btb_assoc_pkg;

  localparam int BTB_SETS  = 64;
  localparam int BTB_WAYS  = 4;
  localparam int BTB_TAG_W = 30;
  localparam int BTB_GHR_W = 8;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // A one-way table still needs a one-bit way field.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

`ifndef BTB_INDEX_HASH
`define BTB_INDEX_HASH(pc_bits, ghr_bits) ((pc_bits) ^ (ghr_bits))
`endif

// File: rtl/btb_way_match.sv
// Tag compare across the ways of one set plus a lowest-way-wins priority encoder.
module btb_way_match
  import btb_assoc_pkg::*;
#(
  parameter int WAYS  = BTB_WAYS,
  parameter int TAG_W = BTB_TAG_W,
  parameter int WAY_W = way_bits(BTB_WAYS)
) (
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]           tag,
  output logic                       hit,
  output logic [WAY_W-1:0]           way
);

  // Scan from the top so the lowest matching way is the last one assigned.
  always_comb begin
    hit = 1'b0;
    way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == tag)) begin
        hit = 1'b1;
        way = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with combinational lookup, round-robin
// replacement and a sequential clear FSM. Define BTB_GHR_HASH_EN to hash ghr_r into the index.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter  int SETS  = BTB_SETS,
  parameter  int WAYS  = BTB_WAYS,
  parameter  int TAG_W = BTB_TAG_W,
  parameter  int GHR_W = BTB_GHR_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = way_bits(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_r,
  input  logic [GHR_W-1:0] ghr_r,
  output logic             hit_r,
  output logic [IDX_W-1:0] index_r,
  output logic [WAY_W-1:0] way_r,
  output logic [31:0]      target_r,
  output logic [1:0]       type_r,
  input  logic             wen,
  input  logic [IDX_W-1:0] index_w,
  input  logic [31:0]      pc_w,
  input  logic [31:0]      target_w,
  input  logic [1:0]       type_w,
  input  logic             inv,
  input  logic [IDX_W-1:0] index_inv,
  input  logic [31:0]      pc_inv,
  input  logic             flush,
  output logic             busy,
  output clr_state_e       clr_state
);

  // Handshake: wen, inv and flush are single-cycle strobes sampled at the rising
  // edge; there is no ready. While busy is high, wen and inv are dropped.

  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0] tag_q   [SETS];
  logic [WAYS-1:0][31:0]      dest_q  [SETS];
  logic [WAYS-1:0][1:0]       btype_q [SETS];
  logic [WAY_W-1:0]           rr_q    [SETS];

  clr_state_e       state_q;
  logic [IDX_W-1:0] clr_idx_q;

  logic [TAG_W-1:0] tag_r;
  logic [TAG_W-1:0] tag_w;
  logic [TAG_W-1:0] tag_inv;
  logic [IDX_W-1:0] idx_lookup;

  logic             rd_hit;
  logic [WAY_W-1:0] rd_way;
  logic             wr_hit;
  logic [WAY_W-1:0] wr_way;
  logic             inv_hit;
  logic [WAY_W-1:0] inv_way;

  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] rr_next;
  logic             alloc_full;
  logic             wr_kill;
  logic             do_write;
  logic             do_inv;
  logic             bypass;

  logic unused_bits;

  assign busy      = (state_q == CLEAR);
  assign clr_state = state_q;

  assign tag_r   = pc_r[TAG_W+1:2];
  assign tag_w   = pc_w[TAG_W+1:2];
  assign tag_inv = pc_inv[TAG_W+1:2];

`ifdef BTB_GHR_HASH_EN
  assign idx_lookup = `BTB_INDEX_HASH(pc_r[IDX_W+1:2], ghr_r[IDX_W-1:0]);
`else
  assign idx_lookup = pc_r[IDX_W+1:2];
`endif

  assign index_r = idx_lookup;

  // Only part of each PC (and possibly none of ghr_r) feeds the tag and index.
  assign unused_bits = ^{pc_r, pc_w, pc_inv, ghr_r};

  btb_way_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_match_rd (
    .valid (valid_q[idx_lookup]),
    .tags  (tag_q[idx_lookup]),
    .tag   (tag_r),
    .hit   (rd_hit),
    .way   (rd_way)
  );

  btb_way_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_match_wr (
    .valid (valid_q[index_w]),
    .tags  (tag_q[index_w]),
    .tag   (tag_w),
    .hit   (wr_hit),
    .way   (wr_way)
  );

  btb_way_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_match_inv (
    .valid (valid_q[index_inv]),
    .tags  (tag_q[index_inv]),
    .tag   (tag_inv),
    .hit   (inv_hit),
    .way   (inv_way)
  );

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[index_w][i]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(i);
      end
    end
  end

  // Existing entry first, then the lowest hole, then the round-robin victim.
  assign victim_way = wr_hit     ? wr_way :
                      free_found ? free_way :
                      (WAYS == 1) ? '0 : rr_q[index_w];

  assign alloc_full = !wr_hit && !free_found;
  assign rr_next    = (WAYS == 1) ? '0 : rr_q[index_w] + WAY_W'(1);

  // A same-cycle invalidate of the very branch being written must leave it invalid,
  // even when the write would otherwise allocate a fresh way.
  assign wr_kill  = inv && (index_inv == index_w) && (tag_inv == tag_w);
  assign do_write = wen && !busy && !wr_kill;
  assign do_inv   = inv && !busy && inv_hit;
  assign bypass   = wen && !busy && (index_w == idx_lookup) && (tag_w == tag_r);

  always_comb begin
    hit_r    = 1'b0;
    way_r    = '0;
    target_r = '0;
    type_r   = BR_COND;
    if (!busy) begin
      if (bypass) begin
        hit_r    = 1'b1;
        way_r    = victim_way;
        target_r = target_w;
        type_r   = type_w;
      end else if (rd_hit) begin
        hit_r    = 1'b1;
        way_r    = rd_way;
        target_r = dest_q[idx_lookup][rd_way];
        type_r   = btype_q[idx_lookup][rd_way];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        CLEAR: begin
          clr_idx_q <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == IDX_W'(SETS - 1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  // Valid bits and rr pointers are cleared one set per cycle by the FSM.
  always_ff @(posedge clk) begin
    if (busy) begin
      valid_q[clr_idx_q] <= '0;
      rr_q[clr_idx_q]    <= '0;
    end else begin
      if (do_write) begin
        valid_q[index_w][victim_way] <= 1'b1;
        if (alloc_full) begin
          rr_q[index_w] <= rr_next;
        end
      end
      if (do_inv) begin
        valid_q[index_inv][inv_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_q[index_w][victim_way]   <= tag_w;
      dest_q[index_w][victim_way]  <= target_w;
      btype_q[index_w][victim_way] <= type_w;
    end
  end

endmodule
